// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: LDPC decoder iteration sequencer.
// Load -> (VNU -> CHECK -> CNU)* -> DONE, with early stop and abort.
module ldpc_iter_ctrl #(
  parameter int MAX_ITER   = 10,
  parameter int ITER_W     = 4,
  parameter int LOAD_BEATS = 8,
  parameter int VNU_LAT    = 1,
  parameter int CNU_LAT    = 2,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              llr_valid,
  output logic              llr_ready,
  input  logic              syn_ok,
  input  logic              out_ack,
  output logic              msg_clr,
  output logic              vnu_en,
  output logic              cnu_en,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_VNU   = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_CNU   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] LOAD_LAST =
    CNT_W'(LOAD_BEATS - 1);
  localparam logic [CNT_W-1:0] VNU_LAST =
    CNT_W'(VNU_LAT - 1);
  localparam logic [CNT_W-1:0] CNU_LAST =
    CNT_W'(CNU_LAT - 1);
  localparam logic [ITER_W-1:0] ITER_MAX =
    ITER_W'(MAX_ITER);

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ITER_W-1:0] iter_d;
  logic              succ_d;
  logic              clr_q, clr_d;
  logic              active;

  // abort only matters while a codeword is in flight
  assign active = (state == S_LOAD)  ||
                  (state == S_VNU)   ||
                  (state == S_CHECK) ||
                  (state == S_CNU);

  // next-state, counter and result computation
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    iter_d  = iter_cnt;
    succ_d  = success;
    clr_d   = 1'b0;
    if (abort && active) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      succ_d  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            cnt_d   = '0;
            iter_d  = '0;
            succ_d  = 1'b0;
            clr_d   = 1'b1;
          end
        end
        S_LOAD: begin
          if (llr_valid) begin
            if (cnt == LOAD_LAST) begin
              state_d = S_VNU;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + 1'b1;
            end
          end
        end
        S_VNU: begin
          if (cnt == VNU_LAST) begin
            state_d = S_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (syn_ok) begin
            state_d = S_DONE;
            succ_d  = 1'b1;
          end else if (iter_cnt == ITER_MAX) begin
            state_d = S_DONE;
            succ_d  = 1'b0;
          end else begin
            state_d = S_CNU;
            cnt_d   = '0;
          end
        end
        S_CNU: begin
          if (cnt == CNU_LAST) begin
            state_d = S_VNU;
            cnt_d   = '0;
            iter_d  = iter_cnt + 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ack) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // state, counters and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      iter_cnt <= '0;
      success  <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      iter_cnt <= iter_d;
      success  <= succ_d;
      clr_q    <= clr_d;
    end
  end

  // strobes and status decode from registered state
  assign llr_ready = (state == S_LOAD);
  assign vnu_en    = (state == S_VNU);
  assign cnu_en    = (state == S_CNU);
  assign done      = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign msg_clr   = clr_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: scoreboard bench for ldpc_iter_ctrl.
// Frame results are predicted at start and checked on done.
module tb_ldpc_iter_ctrl;

  localparam int MAXI = 10;
  localparam int LB   = 8;
  localparam int VL   = 1;
  localparam int CL   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       llr_valid = 1'b0;
  logic       syn_ok;
  logic       out_ack = 1'b0;
  logic       llr_ready, msg_clr, vnu_en, cnu_en;
  logic       busy, done, success;
  logic [3:0] iter_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int conv_at = -1;
  bit gap = 1'b0;
  int cyc = 0, t0 = 0;
  int fv = 0, fc = 0, fr = 0, fb = 0, fm = 0, ph = 0;
  bit busy_q = 1'b0, done_q = 1'b0;

  typedef struct {
    int succ; int iter; int lat;
    int nv; int nc; int nr; int nb; int nm;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  assign syn_ok = (conv_at >= 0) && (fv == conv_at + 1);

  always #5 clk = ~clk;

  ldpc_iter_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .llr_valid(llr_valid), .llr_ready(llr_ready),
    .syn_ok(syn_ok), .out_ack(out_ack),
    .msg_clr(msg_clr), .vnu_en(vnu_en), .cnu_en(cnu_en),
    .busy(busy), .done(done), .success(success),
    .iter_cnt(iter_cnt)
  );

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(int conv, bit g);
    exp_t e;
    int it, ld;
    it = (conv >= 0) ? conv : MAXI;
    ld = g ? (2 * LB - 1) : LB;
    e.succ = (conv >= 0) ? 1 : 0;
    e.iter = it;
    e.lat  = ld + (it + 1) * (VL + 1) + it * CL;
    e.nv   = (it + 1) * VL;
    e.nc   = it * CL;
    e.nr   = ld;
    e.nb   = LB;
    e.nm   = 1;
    return e;
  endfunction

  // monitor: drives llr_valid, counts activity, checks results
  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy && !busy_q) begin
      t0 = cyc;
      fv = 0; fc = 0; fr = 0; fb = 0; fm = 0; ph = 0;
    end
    if (llr_ready) begin
      llr_valid = !gap || (ph % 2 == 0);
      ph++;
      fr++;
      if (llr_valid) fb++;
    end else begin
      llr_valid = 1'b0;
    end
    if (vnu_en) fv++;
    if (cnu_en) fc++;
    if (msg_clr) fm++;
    if (busy)
      chk("excl",
          int'(vnu_en) + int'(cnu_en) + int'(llr_ready) > 1,
          0);
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("succ", success, me.succ);
        chk("iter", iter_cnt, me.iter);
        chk("lat", cyc - t0, me.lat);
        chk("vnu_cyc", fv, me.nv);
        chk("cnu_cyc", fc, me.nc);
        chk("rdy_cyc", fr, me.nr);
        chk("beats", fb, me.nb);
        chk("clr_cyc", fm, me.nm);
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic wait_done();
    int k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("done_to", done, 1);
  endtask

  task automatic run_frame(int conv, bit g, int dly, bit tog);
    exp_t e;
    e = model(conv, g);
    conv_at = conv;
    gap = g;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ld_busy", busy, 1);
    chk("ld_clr", msg_clr, 1);
    chk("ld_rdy", llr_ready, 1);
    chk("ld_iter", iter_cnt, 0);
    wait_done();
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (tog) begin
        start = ~start;
        abort = 1'($urandom_range(0, 1));
      end
      chk("hold_done", done, 1);
      chk("hold_succ", success, e.succ);
      chk("hold_iter", iter_cnt, e.iter);
    end
    start = 1'b0;
    abort = 1'b0;
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    chk("ack_busy", busy, 0);
    chk("ack_done", done, 0);
  endtask

  initial begin
    int k;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_succ", success, 0);
    chk("rst_iter", iter_cnt, 0);
    chk("rst_rdy", llr_ready, 0);
    chk("rst_clr", msg_clr, 0);
    chk("rst_vnu", vnu_en, 0);
    chk("rst_cnu", cnu_en, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_frame(0, 1'b0, 0, 1'b0);
    run_frame(-1, 1'b0, 2, 1'b0);
    run_frame(3, 1'b1, 1, 1'b0);

    conv_at = 1;
    gap = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(vnu_en && iter_cnt == 1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("ab_find", vnu_en, 1);
    @(negedge clk);
    chk("ab_check",
        busy && !vnu_en && !cnu_en && !llr_ready, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_succ", success, 0);
    chk("ab_iter", iter_cnt, 1);
    chk("ab_rdy", llr_ready, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ab_nodone", done, 0);
    end
    run_frame(0, 1'b0, 0, 1'b0);

    run_frame(2, 1'b0, 20, 1'b1);

    conv_at = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(cnu_en && iter_cnt == 1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("rs_find", cnu_en, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_succ", success, 0);
    chk("rs_iter", iter_cnt, 0);
    chk("rs_rdy", llr_ready, 0);
    chk("rs_clr", msg_clr, 0);
    chk("rs_vnu", vnu_en, 0);
    chk("rs_cnu", cnu_en, 0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(0, 1'b0, 0, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ldpc_iter_ctrl.md
# ldpc_iter_ctrl

Iteration controller for the LDPC decoder core. Sequences one codeword through channel-LLR load, alternating variable-node (VNU) and check-node (CNU) update phases, and a per-iteration syndrome check. Terminates early on a zero syndrome or after `MAX_ITER` iterations, and reports iteration count and success to the downstream consumer. Sits between the frame input interface and the VNU/CNU arrays; it only drives their enables, and the message-clear strobe is driven into the arrays' active-high message-register reset.

## Interface

Parameters:
- `MAX_ITER`, 10: maximum CNU passes before forced termination (1..2^ITER_W-1).
- `ITER_W`, 4: width of iteration counter.
- `LOAD_BEATS`, 8: accepted LLR beats per codeword (≥1).
- `VNU_LAT`, 1: cycles `vnu_en` is held per VNU phase (≥1).
- `CNU_LAT`, 2: cycles `cnu_en` is held per CNU phase (≥1).
- `CNT_W`, 8: width of internal beat/phase counter; must hold max(LOAD_BEATS, VNU_LAT, CNU_LAT).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a codeword; sampled only in IDLE.
- `abort` in 1: synchronous abandon of the current codeword.
- `llr_valid` in 1: channel LLR beat present.
- `llr_ready` out 1: controller accepts LLR beats.
- `syn_ok` in 1: syndrome of current hard decisions is all-zero; sampled only in CHECK.
- `out_ack` in 1: consumer has taken the result.
- `msg_clr` out 1: one-cycle strobe clearing VNU/CNU message registers.
- `vnu_en` out 1: VNU array update enable.
- `cnu_en` out 1: CNU array update enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: result valid, held until acknowledged.
- `success` out 1: codeword converged (valid while `done`).
- `iter_cnt` out ITER_W: CNU passes completed for the current codeword.

## Operation

- States: IDLE, LOAD, VNU, CHECK, CNU, DONE. State, counters and all outputs are registered; outputs decode from registered state only.
- IDLE: `start`=1 -> LOAD; `msg_clr`=1 during the first LOAD cycle only; `iter_cnt` cleared to 0; beat counter cleared.
- LOAD: `llr_ready`=1; a beat is accepted when `llr_valid`&&`llr_ready`. On the LOAD_BEATS-th accepted beat -> VNU. Gaps in `llr_valid` stall indefinitely.
- VNU: `vnu_en`=1 for exactly VNU_LAT consecutive cycles, then -> CHECK.
- CHECK: one cycle, all enables low. If `syn_ok`=1 -> DONE with `success`=1. Else if `iter_cnt`==MAX_ITER -> DONE with `success`=0. Else -> CNU.
- CNU: `cnu_en`=1 for exactly CNU_LAT cycles; on the last cycle `iter_cnt` increments, then -> VNU.
- DONE: `done`=1, `success` and `iter_cnt` frozen. `out_ack`=1 -> IDLE. `start` in DONE is ignored.
- `abort`=1 in LOAD/VNU/CHECK/CNU -> IDLE next cycle; `done` never asserts for that codeword; `iter_cnt` holds its last value; `success` cleared. `abort` in IDLE or DONE is ignored (DONE still waits for `out_ack`).
- `abort` has priority over every other transition in the same cycle, including `syn_ok` in CHECK and the final LLR beat in LOAD.
- `vnu_en`, `cnu_en`, `llr_ready`, `msg_clr` are mutually exclusive; never two high in one cycle.
- `iter_cnt` never exceeds MAX_ITER; no wrap.

## Timing

- Reset (`rst`=0, asynchronous): state IDLE; `llr_ready`, `msg_clr`, `vnu_en`, `cnu_en`, `busy`, `done`, `success` all 0; `iter_cnt`=0; counters 0. Reset mid-operation discards the codeword immediately.
- `start` at edge k -> `busy`=`llr_ready`=`msg_clr`=1 from cycle k+1.
- Minimum frame: LOAD_BEATS cycles load + VNU_LAT + 1 check -> `done` on cycle after CHECK. Each extra iteration adds CNU_LAT+VNU_LAT+1 cycles.
- Worst case (no convergence): LOAD_BEATS + (MAX_ITER+1)·(VNU_LAT+1) + MAX_ITER·CNU_LAT cycles from first LOAD cycle to first DONE cycle.
- `out_ack` sampled in DONE -> IDLE next cycle; `done`, `busy` low that cycle; a new `start` accepted one cycle later at earliest.

## Test plan

- Reset mid-CNU: drive `rst`=0 asynchronously -> all outputs 0, `iter_cnt`=0 without waiting for a clock edge.
- Immediate convergence, defaults: 8 back-to-back beats, `syn_ok`=1 in first CHECK -> `vnu_en` 1 cycle, `done`=1, `success`=1, `iter_cnt`=0, 10 cycles after `start`.
- No convergence, defaults: `syn_ok`=0 always -> exactly 10 `cnu_en` bursts of 2 cycles, 11 `vnu_en` pulses, `done`=1, `success`=0, `iter_cnt`=10.
- Convergence at iteration 3, LLR beats with 1-cycle gaps: `syn_ok`=1 in 4th CHECK -> `iter_cnt`=3, `success`=1; `llr_ready` high for 15 cycles, 8 beats counted.
- Abort vs. syn_ok: `abort`=1 and `syn_ok`=1 in the same CHECK cycle -> IDLE, `done` never asserts, `success`=0; next `start` produces `msg_clr` pulse and `iter_cnt`=0.
- DONE hold: delay `out_ack` 20 cycles, toggle `start` and `abort` meanwhile -> `done`, `success`, `iter_cnt` stable; IDLE one cycle after `out_ack`.
